// File: rtl/msx_bus_pkg.sv
// Shared types for the MSX slot bus initiator: FSM states, latched request, open-bus value.
package msx_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        T1,
        T2,
        TWA,
        TW,
        T3,
        DONE
    } state_t;

    typedef struct packed {
        logic        write;
        logic        io;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } req_t;

    localparam logic [7:0] OPEN_BUS = 8'hFF;

endpackage

// File: rtl/msx_tstate_timer.sv
// Divides CLK into Z80 T-states; tick marks the last CLK of each T-state.
module msx_tstate_timer #(
    parameter int T_DIV = 6
) (
    input  logic CLK,
    input  logic RESET_n,
    input  logic restart,
    output logic tick
);

    localparam logic [3:0] LAST = 4'(T_DIV - 1);

    logic [3:0] r_cnt;

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            r_cnt <= '0;
        end else if (restart || (r_cnt == LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 4'd1;
        end
    end

    assign tick = (r_cnt == LAST);

endmodule

// File: rtl/msx_bus_initiator.sv
// MSX slot bus initiator: turns single memory/I/O requests into Z80-timed slot cycles.
// Optional WAIT_n watchdog enabled by defining MSX_BUS_INITIATOR_WDOG_EN.
module msx_bus_initiator
    import msx_bus_pkg::*;
#(
    parameter int T_DIV  = 6,
    parameter int WDOG_T = 256
) (
    input  logic        CLK,
    input  logic        RESET_n,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic        REQ_WRITE,
    input  logic        REQ_IO,
    input  logic [15:0] REQ_ADDR,
    input  logic [7:0]  REQ_WDATA,
    output logic        RSP_VALID,
    output logic [7:0]  RSP_RDATA,
    output logic        RSP_ERR,
    output logic [15:0] ADDR,
    output logic [7:0]  DOUT,
    input  logic [7:0]  DIN,
    output logic        SLTSL_n,
    output logic        MERQ_n,
    output logic        IORQ_n,
    output logic        RD_n,
    output logic        WR_n,
    input  logic        WAIT_n,
    input  logic        BUSDIR_n
);

    state_t      r_state;
    req_t        r_req;
    logic        r_ready;
    logic [15:0] r_addr;
    logic [7:0]  r_dout;
    logic        r_sltsl_n, r_merq_n, r_iorq_n, r_rd_n, r_wr_n;
    logic        r_rsp_valid;
    logic [7:0]  r_rdata;
    logic        w_tick;
    logic        w_accept;

`ifdef MSX_BUS_INITIATOR_WDOG_EN
    localparam logic [15:0] WDOG_LAST = 16'(WDOG_T - 1);
    logic        r_err;
    logic [15:0] r_wdog;
`endif

    assign w_accept = (r_state == IDLE) && r_ready && REQ_VALID;

    msx_tstate_timer #(.T_DIV(T_DIV)) u_timer (
        .CLK     (CLK),
        .RESET_n (RESET_n),
        .restart (w_accept),
        .tick    (w_tick)
    );

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            r_state     <= IDLE;
            r_req       <= '0;
            r_ready     <= 1'b0;
            r_addr      <= '0;
            r_dout      <= '0;
            r_sltsl_n   <= 1'b1;
            r_merq_n    <= 1'b1;
            r_iorq_n    <= 1'b1;
            r_rd_n      <= 1'b1;
            r_wr_n      <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rdata     <= OPEN_BUS;
`ifdef MSX_BUS_INITIATOR_WDOG_EN
            r_err       <= 1'b0;
            r_wdog      <= '0;
`endif
        end else begin
            r_rsp_valid <= 1'b0;
`ifdef MSX_BUS_INITIATOR_WDOG_EN
            r_err       <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_req   <= '{write: REQ_WRITE, io: REQ_IO, addr: REQ_ADDR, wdata: REQ_WDATA};
                        r_addr  <= REQ_ADDR;
                        if (REQ_WRITE) r_dout <= REQ_WDATA;
                        r_ready <= 1'b0;
                        r_state <= T1;
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                T1: begin
                    if (w_tick) begin
                        if (r_req.io) begin
                            r_iorq_n <= 1'b0;
                        end else begin
                            r_merq_n  <= 1'b0;
                            r_sltsl_n <= 1'b0;
                        end
                        if (r_req.write) r_wr_n <= 1'b0;
                        else             r_rd_n <= 1'b0;
                        r_state <= T2;
                    end
                end
                T2: begin
                    if (w_tick) begin
                        if (r_req.io)    r_state <= TWA;
                        else if (WAIT_n) r_state <= T3;
                        else             r_state <= TW;
                    end
                end
                TWA: begin
                    if (w_tick) r_state <= WAIT_n ? T3 : TW;
                end
                TW: begin
`ifdef MSX_BUS_INITIATOR_WDOG_EN
                    if (w_tick) begin
                        if (WAIT_n) begin
                            r_state <= T3;
                            r_wdog  <= '0;
                        end else if (r_wdog == WDOG_LAST) begin
                            // Abort: release the bus without touching the read data.
                            r_sltsl_n   <= 1'b1;
                            r_merq_n    <= 1'b1;
                            r_iorq_n    <= 1'b1;
                            r_rd_n      <= 1'b1;
                            r_wr_n      <= 1'b1;
                            r_rsp_valid <= 1'b1;
                            r_err       <= 1'b1;
                            r_wdog      <= '0;
                            r_state     <= DONE;
                        end else begin
                            r_wdog <= r_wdog + 16'd1;
                        end
                    end
`else
                    if (w_tick && WAIT_n) r_state <= T3;
`endif
                end
                T3: begin
                    if (w_tick) begin
                        if (!r_req.write) begin
                            r_rdata <= (r_req.io && BUSDIR_n) ? OPEN_BUS : DIN;
                        end
                        r_sltsl_n   <= 1'b1;
                        r_merq_n    <= 1'b1;
                        r_iorq_n    <= 1'b1;
                        r_rd_n      <= 1'b1;
                        r_wr_n      <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign REQ_READY = r_ready;
    assign RSP_VALID = r_rsp_valid;
    assign RSP_RDATA = r_rdata;
    assign ADDR      = r_addr;
    assign DOUT      = r_dout;
    assign SLTSL_n   = r_sltsl_n;
    assign MERQ_n    = r_merq_n;
    assign IORQ_n    = r_iorq_n;
    assign RD_n      = r_rd_n;
    assign WR_n      = r_wr_n;
`ifdef MSX_BUS_INITIATOR_WDOG_EN
    assign RSP_ERR   = r_err;
`else
    assign RSP_ERR   = 1'b0;
`endif

endmodule

// File: tb/tb_msx_bus_initiator.sv
// Testbench for msx_bus_initiator: directed and random bus cycles checked against a T-state model.
// Adds a watchdog abort scenario when MSX_BUS_INITIATOR_WDOG_EN is defined.
module tb_msx_bus_initiator;

    localparam int TD = 6;
`ifdef MSX_BUS_INITIATOR_WDOG_EN
    localparam int WD = 4;
`else
    localparam int WD = 256;
`endif

    logic        CLK = 1'b0;
    logic        RESET_n = 1'b0;
    logic        REQ_VALID = 1'b0;
    logic        REQ_READY;
    logic        REQ_WRITE = 1'b0;
    logic        REQ_IO = 1'b0;
    logic [15:0] REQ_ADDR = '0;
    logic [7:0]  REQ_WDATA = '0;
    logic        RSP_VALID;
    logic [7:0]  RSP_RDATA;
    logic        RSP_ERR;
    logic [15:0] ADDR;
    logic [7:0]  DOUT;
    logic [7:0]  DIN = '0;
    logic        SLTSL_n, MERQ_n, IORQ_n, RD_n, WR_n;
    logic        WAIT_n = 1'b1;
    logic        BUSDIR_n = 1'b1;

    int checks = 0;
    int errors = 0;

    // Responder and bus monitor state
    int          waitLen = 0;
    int          strobeCnt = 0;
    logic [7:0]  respData = '0;
    logic [15:0] expAddr = '0;
    logic [7:0]  expWdata = '0;
    bit          expWrite = 1'b0;
    int lowSl, lowMerq, lowIorq, lowRd, lowWr, busBad, rspPulses;
    logic [7:0]  modelRdata = 8'hFF;

    msx_bus_initiator #(.T_DIV(TD), .WDOG_T(WD)) dut (
        .CLK(CLK), .RESET_n(RESET_n),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WRITE(REQ_WRITE),
        .REQ_IO(REQ_IO), .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
        .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
        .ADDR(ADDR), .DOUT(DOUT), .DIN(DIN),
        .SLTSL_n(SLTSL_n), .MERQ_n(MERQ_n), .IORQ_n(IORQ_n), .RD_n(RD_n), .WR_n(WR_n),
        .WAIT_n(WAIT_n), .BUSDIR_n(BUSDIR_n)
    );

    always #5 CLK = ~CLK;

    // Cartridge holds WAIT_n low for the first waitLen cycles of the strobed phase.
    always @(negedge CLK) begin
        if (!MERQ_n || !IORQ_n) strobeCnt = strobeCnt + 1;
        else                    strobeCnt = 0;
        WAIT_n = !(strobeCnt >= 1 && strobeCnt <= waitLen);
        DIN    = WAIT_n ? respData : ~respData;
    end

    always @(negedge CLK) begin
        if (!SLTSL_n) lowSl++;
        if (!MERQ_n)  lowMerq++;
        if (!IORQ_n)  lowIorq++;
        if (!RD_n)    lowRd++;
        if (!WR_n)    lowWr++;
        if (!MERQ_n || !IORQ_n || !RD_n || !WR_n) begin
            if (ADDR !== expAddr) busBad++;
            if (expWrite && DOUT !== expWdata) busBad++;
        end
        if (RSP_VALID) rspPulses++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clearMonitor();
        lowSl = 0; lowMerq = 0; lowIorq = 0; lowRd = 0; lowWr = 0; busBad = 0; rspPulses = 0;
    endtask

    // One complete transfer; expectations come from counting T-states.
    task automatic applyStimulus(input bit wr, input bit io, input logic [15:0] addr,
                                 input logic [7:0] wd, input logic [7:0] rd, input int wl,
                                 input bit busdir, input bit expErr);
        int nTw, expLat, lows, lat, n;
        bit done;
        if (expErr) begin
            nTw  = WD;
            lows = (1 + nTw) * TD;
            expLat = (2 + nTw) * TD + 1;
        end else begin
            nTw = wl / TD;
            if (io) nTw = (nTw > 0) ? nTw - 1 : 0;
            lows = (2 + (io ? 1 : 0) + nTw) * TD;
            expLat = lows + TD + 1;
        end
        waitLen = wl; respData = rd; BUSDIR_n = busdir;
        expAddr = addr; expWrite = wr; expWdata = wd;
        @(negedge CLK);
        clearMonitor();
        REQ_WRITE = wr; REQ_IO = io; REQ_ADDR = addr; REQ_WDATA = wd; REQ_VALID = 1'b1;
        n = 0;
        while (!REQ_READY && n < 50) begin
            @(negedge CLK);
            n++;
        end
        checkOutput("req_ready_idle", 32'(REQ_READY), 32'd1);
        lat = 0; done = 1'b0;
        while (!done && lat < 400) begin
            @(posedge CLK);
            lat++;
            if (lat == 1) #1 REQ_VALID = 1'b0;
            @(negedge CLK);
            if (lat == 1) begin
                checkOutput("t1_addr", 32'(ADDR), 32'(addr));
                checkOutput("t1_ready_low", 32'(REQ_READY), 32'd0);
                checkOutput("t1_strobes", 32'({SLTSL_n, MERQ_n, IORQ_n, RD_n, WR_n}), 32'h1F);
                if (wr) checkOutput("t1_dout", 32'(DOUT), 32'(wd));
            end
            if (RSP_VALID) done = 1'b1;
        end
        if (!wr && !expErr) modelRdata = (io && busdir) ? 8'hFF : rd;
        checkOutput("latency", 32'(lat), 32'(expLat));
        checkOutput("rsp_err", 32'(RSP_ERR), 32'(expErr));
        checkOutput("rsp_rdata", 32'(RSP_RDATA), 32'(modelRdata));
        checkOutput("done_strobes", 32'({SLTSL_n, MERQ_n, IORQ_n, RD_n, WR_n}), 32'h1F);
        @(negedge CLK);
        checkOutput("rsp_one_cycle", 32'(RSP_VALID), 32'd0);
        checkOutput("low_sltsl", 32'(lowSl), io ? 32'd0 : 32'(lows));
        checkOutput("low_merq", 32'(lowMerq), io ? 32'd0 : 32'(lows));
        checkOutput("low_iorq", 32'(lowIorq), io ? 32'(lows) : 32'd0);
        checkOutput("low_rd", 32'(lowRd), wr ? 32'd0 : 32'(lows));
        checkOutput("low_wr", 32'(lowWr), wr ? 32'(lows) : 32'd0);
        checkOutput("bus_addr_dout", 32'(busBad), 32'd0);
        checkOutput("rsp_pulses", 32'(rspPulses), 32'd1);
        waitLen = 0;
    endtask

    initial begin
        int n;
        #12;
        checkOutput("reset_strobes", 32'({SLTSL_n, MERQ_n, IORQ_n, RD_n, WR_n}), 32'h1F);
        checkOutput("reset_addr", 32'(ADDR), 32'd0);
        checkOutput("reset_dout", 32'(DOUT), 32'd0);
        checkOutput("reset_ready", 32'(REQ_READY), 32'd0);
        checkOutput("reset_rsp_valid", 32'(RSP_VALID), 32'd0);
        checkOutput("reset_rdata", 32'(RSP_RDATA), 32'hFF);
        checkOutput("reset_err", 32'(RSP_ERR), 32'd0);
        @(negedge CLK);
        RESET_n = 1'b1;
        @(negedge CLK);
        checkOutput("ready_after_reset", 32'(REQ_READY), 32'd1);

        $display("[TB] directed transfers");
        applyStimulus(1'b0, 1'b0, 16'h4000, 8'h00, 8'hA5, 0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 16'h9800, 8'h3F, 8'h11, 0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'h6000, 8'h00, 8'h5A, 3 * TD, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 16'h00A0, 8'h00, 8'h77, 0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 16'h0098, 8'h00, 8'hC3, 0, 1'b0, 1'b0);

        $display("[TB] random transfers");
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom),
                          8'($urandom), 8'($urandom), int'($urandom_range(0, 3 * TD + 2)),
                          1'($urandom_range(0, 1)), 1'b0);
        end

        $display("[TB] reset during T2");
        expAddr = 16'h4000; expWrite = 1'b0; respData = 8'h99; waitLen = 0;
        @(negedge CLK);
        clearMonitor();
        REQ_WRITE = 1'b0; REQ_IO = 1'b0; REQ_ADDR = 16'h4000; REQ_VALID = 1'b1;
        @(posedge CLK);
        #1 REQ_VALID = 1'b0;
        n = 0;
        while (MERQ_n && n < 50) begin
            @(negedge CLK);
            n++;
        end
        checkOutput("t2_reached", 32'(MERQ_n), 32'd0);
        #2 RESET_n = 1'b0;
        #1;
        checkOutput("async_strobes", 32'({SLTSL_n, MERQ_n, IORQ_n, RD_n, WR_n}), 32'h1F);
        checkOutput("async_ready", 32'(REQ_READY), 32'd0);
        repeat (2) @(negedge CLK);
        RESET_n = 1'b1;
        modelRdata = 8'hFF;
        repeat (30) @(negedge CLK);
        checkOutput("no_rsp_after_reset", 32'(rspPulses), 32'd0);
        checkOutput("ready_after_abort", 32'(REQ_READY), 32'd1);
        checkOutput("rdata_after_abort", 32'(RSP_RDATA), 32'hFF);
        applyStimulus(1'b0, 1'b0, 16'h4000, 8'h00, 8'hA5, 0, 1'b1, 1'b0);

`ifdef MSX_BUS_INITIATOR_WDOG_EN
        $display("[TB] watchdog abort");
        applyStimulus(1'b0, 1'b0, 16'h8000, 8'h00, 8'h3C, 100000, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 16'h8001, 8'h00, 8'h3D, 0, 1'b1, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
